// File: rtl/cpu_uc_pkg.sv
// Shared microcode-control definitions: sequencing op codes, flag select codes
// and ALU flag bit positions.
package cpu_uc_pkg;

   localparam int unsigned SEQ_OP_W = 3;
   localparam int unsigned COND_W   = 2;
   localparam int unsigned FLAGS_W  = 4;

   typedef enum logic [SEQ_OP_W-1:0] {
      SEQ_NEXT  = 3'd0,
      SEQ_JUMP  = 3'd1,
      SEQ_CBR   = 3'd2,
      SEQ_MAP   = 3'd3,
      SEQ_CALL  = 3'd4,
      SEQ_RET   = 3'd5,
      SEQ_FETCH = 3'd6,
      SEQ_HALT  = 3'd7
   } seq_op_e;

   localparam logic [COND_W-1:0] COND_Z = 2'd0;
   localparam logic [COND_W-1:0] COND_N = 2'd1;
   localparam logic [COND_W-1:0] COND_C = 2'd2;
   localparam logic [COND_W-1:0] COND_V = 2'd3;

   // FLAGS bus is {V,C,N,Z}
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO for microcode CALL/RET. Overflowing pushes and
// underflowing pops are ignored; the caller decides how to flag them.
module micro_stack #(
   parameter int unsigned STACK_D = 4,
   parameter int unsigned UA_W    = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [UA_W-1:0] wdata_i,
   output logic [UA_W-1:0] top_c,
   output logic            full_c,
   output logic            empty_c
);

   localparam int unsigned IDX_W = $clog2(STACK_D);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [SP_W-1:0]  sp_q, sp_d;
   logic [SP_W-1:0]  sp_m1;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [UA_W-1:0]  mem_q [STACK_D];

   assign full_c  = (sp_q == SP_W'(STACK_D));
   assign empty_c = (sp_q == '0);
   assign sp_m1   = sp_q - SP_W'(1);
   assign wr_idx  = sp_q[IDX_W-1:0];
   assign rd_idx  = sp_m1[IDX_W-1:0];
   assign top_c   = mem_q[rd_idx];

   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_c) begin
         sp_d = sp_q + SP_W'(1);
      end else if (pop_i && !empty_c) begin
         sp_d = sp_m1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Contents are don't-care after reset, so storage carries no reset.
   always_ff @(posedge clk) begin
      if (push_i && !full_c) begin
         mem_q[wr_idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microaddress generator: owns the micro-PC, selects increment, jump,
// conditional branch, opcode dispatch or call/return each unstalled cycle.
module micro_sequencer
   import cpu_uc_pkg::*;
#(
   parameter int unsigned UA_W    = 8,
   parameter int unsigned OP_W    = 4,
   parameter int unsigned STACK_D = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall_i,
   input  logic [SEQ_OP_W-1:0] seq_op_i,
   input  logic [COND_W-1:0]   cond_sel_i,
   input  logic                cond_pol_i,
   input  logic [UA_W-1:0]     uaddr_i,
   input  logic [OP_W-1:0]     opcode_i,
   input  logic [FLAGS_W-1:0]  flags_i,
   output logic [UA_W-1:0]     upc_o,
   output logic                dispatch_o,
   output logic                halted_o,
   output logic                stack_err_o
);

   logic [UA_W-1:0] upc_q, upc_d;
   logic            dispatch_q, dispatch_d;
   logic            halted_q, halted_d;
   logic            err_q, err_d;

   logic [UA_W-1:0] upc_inc;
   logic [UA_W-1:0] map_addr;
   logic            cond;
   logic            push, pop;
   logic [UA_W-1:0] stk_top;
   logic            stk_full, stk_empty;

   assign upc_inc  = upc_q + UA_W'(1);
   assign map_addr = {opcode_i, {(UA_W-OP_W){1'b0}}};
   assign cond     = flags_i[cond_sel_i] ^ cond_pol_i;

   micro_stack #(
      .STACK_D (STACK_D),
      .UA_W    (UA_W)
   ) u_stack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (upc_inc),
      .top_c   (stk_top),
      .full_c  (stk_full),
      .empty_c (stk_empty)
   );

   // Stall dominates everything, halt freezes everything but reset.
   always_comb begin
      upc_d      = upc_q;
      dispatch_d = 1'b0;
      halted_d   = halted_q;
      err_d      = err_q;
      push       = 1'b0;
      pop        = 1'b0;
      if (!stall_i && !halted_q) begin
         case (seq_op_e'(seq_op_i))
            SEQ_NEXT:  upc_d = upc_inc;
            SEQ_JUMP:  upc_d = uaddr_i;
            SEQ_CBR:   upc_d = cond ? uaddr_i : upc_inc;
            SEQ_MAP: begin
               upc_d      = map_addr;
               dispatch_d = 1'b1;
            end
            SEQ_CALL: begin
               upc_d = uaddr_i;
               if (stk_full) begin
                  err_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
            SEQ_RET: begin
               if (stk_empty) begin
                  err_d = 1'b1;
                  upc_d = '0;
               end else begin
                  pop   = 1'b1;
                  upc_d = stk_top;
               end
            end
            SEQ_FETCH: upc_d = '0;
            SEQ_HALT:  halted_d = 1'b1;
            default:   upc_d = upc_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upc_q      <= '0;
         dispatch_q <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         upc_q      <= upc_d;
         dispatch_q <= dispatch_d;
         halted_q   <= halted_d;
         err_q      <= err_d;
      end
   end

   assign upc_o       = upc_q;
   assign dispatch_o  = dispatch_q;
   assign halted_o    = halted_q;
   assign stack_err_o = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expected micro-PCs.
module tb_micro_sequencer;
   import cpu_uc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stall;
   logic [2:0] seq_op;
   logic [1:0] cond_sel;
   logic       cond_pol;
   logic [7:0] uaddr;
   logic [3:0] opcode;
   logic [3:0] flags;
   logic [7:0] upc;
   logic       dispatch, halted, stack_err;

   int vectors = 0;
   int errors  = 0;

   micro_sequencer #(.UA_W(8), .OP_W(4), .STACK_D(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (stall),
      .seq_op_i    (seq_op),
      .cond_sel_i  (cond_sel),
      .cond_pol_i  (cond_pol),
      .uaddr_i     (uaddr),
      .opcode_i    (opcode),
      .flags_i     (flags),
      .upc_o       (upc),
      .dispatch_o  (dispatch),
      .halted_o    (halted),
      .stack_err_o (stack_err)
   );

   always #5 clk = ~clk;

   // Apply one microword, then sample just after the edge that consumes it.
   task automatic step(input logic [2:0] op, input logic [7:0] ua);
      seq_op = op;
      uaddr  = ua;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; seq_op = SEQ_NEXT; cond_sel = COND_Z;
      cond_pol = 1'b0; uaddr = '0; opcode = '0; flags = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({upc, dispatch, halted, stack_err} !== 11'h0) begin
         errors++;
         $display("FAIL reset: got upc=%h d=%b h=%b e=%b expected all 0", upc, dispatch, halted, stack_err);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_next();
      for (int i = 1; i <= 3; i++) begin
         step(SEQ_NEXT, 8'h00);
         vectors++;
         if (upc !== 8'(i)) begin
            errors++;
            $display("FAIL next%0d: got %h expected %h", i, upc, 8'(i));
         end
      end
      step(SEQ_JUMP, 8'hFF);
      step(SEQ_NEXT, 8'h00);
      vectors++;
      if (upc !== 8'h00 || stack_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap: got upc=%h err=%b expected upc=00 err=0", upc, stack_err);
      end
   endtask

   task automatic test_cbr();
      flags = 4'b0001; cond_sel = COND_Z; cond_pol = 1'b0;
      step(SEQ_CBR, 8'h40);
      vectors++;
      if (upc !== 8'h40) begin
         errors++;
         $display("FAIL cbr_taken: got %h expected 40", upc);
      end
      step(SEQ_JUMP, 8'h10);
      cond_pol = 1'b1;
      step(SEQ_CBR, 8'h40);
      vectors++;
      if (upc !== 8'h11) begin
         errors++;
         $display("FAIL cbr_not_taken: got %h expected 11", upc);
      end
      flags = 4'b1000; cond_sel = COND_V; cond_pol = 1'b0;
      step(SEQ_CBR, 8'h77);
      vectors++;
      if (upc !== 8'h77) begin
         errors++;
         $display("FAIL cbr_v: got %h expected 77", upc);
      end
      cond_pol = 1'b0; flags = '0;
   endtask

   task automatic test_map();
      opcode = 4'hA;
      step(SEQ_MAP, 8'h00);
      vectors++;
      if (upc !== 8'hA0 || dispatch !== 1'b1) begin
         errors++;
         $display("FAIL map: got upc=%h d=%b expected upc=a0 d=1", upc, dispatch);
      end
      step(SEQ_NEXT, 8'h00);
      vectors++;
      if (upc !== 8'hA1 || dispatch !== 1'b0) begin
         errors++;
         $display("FAIL map_pulse: got upc=%h d=%b expected upc=a1 d=0", upc, dispatch);
      end
   endtask

   task automatic test_call_ret();
      logic [7:0] exp_seq [4] = '{8'h20, 8'h30, 8'h22, 8'h06};
      logic [2:0] ops     [4] = '{SEQ_CALL, SEQ_CALL, SEQ_RET, SEQ_RET};
      logic [7:0] tgt     [4] = '{8'h20, 8'h30, 8'h00, 8'h00};
      step(SEQ_JUMP, 8'h05);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) step(SEQ_NEXT, 8'h00);  // 20 -> 21
         step(ops[i], tgt[i]);
         vectors++;
         if (upc !== exp_seq[i]) begin
            errors++;
            $display("FAIL call_ret%0d: got %h expected %h", i, upc, exp_seq[i]);
         end
      end
      vectors++;
      if (stack_err !== 1'b0) begin
         errors++;
         $display("FAIL call_ret_err: got %b expected 0", stack_err);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] rets [5] = '{8'h31, 8'h21, 8'h11, 8'h01, 8'h00};
      step(SEQ_JUMP, 8'h00);
      for (int i = 1; i <= 4; i++) step(SEQ_CALL, 8'(i * 16));
      vectors++;
      if (stack_err !== 1'b0) begin
         errors++;
         $display("FAIL ovf_early: got err=%b expected 0", stack_err);
      end
      step(SEQ_CALL, 8'h50);
      vectors++;
      if (upc !== 8'h50 || stack_err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_call: got upc=%h err=%b expected upc=50 err=1", upc, stack_err);
      end
      for (int i = 0; i < 5; i++) begin
         step(SEQ_RET, 8'h00);
         vectors++;
         if (upc !== rets[i]) begin
            errors++;
            $display("FAIL ovf_ret%0d: got %h expected %h", i, upc, rets[i]);
         end
      end
      vectors++;
      if (stack_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 1", stack_err);
      end
   endtask

   task automatic test_stall();
      opcode = 4'h3;
      step(SEQ_MAP, 8'h00);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(SEQ_JUMP, 8'h99);
         vectors++;
         if (upc !== 8'h30 || dispatch !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d: got upc=%h d=%b expected upc=30 d=0", i, upc, dispatch);
         end
      end
      stall = 1'b0;
      step(SEQ_JUMP, 8'h99);
      vectors++;
      if (upc !== 8'h99) begin
         errors++;
         $display("FAIL stall_release: got %h expected 99", upc);
      end
      stall = 1'b1;
      step(SEQ_HALT, 8'h00);
      vectors++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL stall_halt: got halted=%b expected 0", halted);
      end
      stall = 1'b0;
   endtask

   task automatic test_halt();
      step(SEQ_HALT, 8'h00);
      vectors++;
      if (halted !== 1'b1 || upc !== 8'h99) begin
         errors++;
         $display("FAIL halt: got h=%b upc=%h expected h=1 upc=99", halted, upc);
      end
      step(SEQ_JUMP, 8'h12);
      step(SEQ_FETCH, 8'h00);
      vectors++;
      if (halted !== 1'b1 || upc !== 8'h99) begin
         errors++;
         $display("FAIL halt_frozen: got h=%b upc=%h expected h=1 upc=99", halted, upc);
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({upc, dispatch, halted, stack_err} !== 11'h0) begin
         errors++;
         $display("FAIL async_reset: got upc=%h d=%b h=%b e=%b expected all 0", upc, dispatch, halted, stack_err);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(SEQ_NEXT, 8'h00);
      vectors++;
      if (upc !== 8'h01 || halted !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got upc=%h h=%b expected upc=01 h=0", upc, halted);
      end
   endtask

   initial begin
      test_reset();
      test_next();
      test_cbr();
      test_map();
      test_call_ret();
      test_overflow();
      test_stall();
      test_halt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
